// File: rtl/path_reader.sv
// path_reader: drains a location stack into a local path buffer, then
// replays the buffer in reverse pop order so the path comes out start-to-end.
// Each popped entry takes three cycles (CHK -> POP -> CAP). The replay phase
// can emit one word per cycle when the downstream keeps outReady high.
module path_reader #(
    parameter int W     = 8,
    parameter int DEPTH = 64,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stkEmpty,
    input  logic [W-1:0]  stkLoc,
    output logic          stkPop,
    output logic [W-1:0]  outLoc,
    output logic          outValid,
    input  logic          outReady,
    output logic [CW-1:0] pathLen,
    output logic          busy,
    output logic          done,
    output logic          ovf
);

    typedef enum logic [2:0] {
        IDLE,
        CHK,
        POP,
        CAP,
        EMIT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] len_q, len_d;
    logic          ovf_q, ovf_d;
    logic          wr_en;

    // Path storage. It has no reset: replay only reads slots written during
    // the current drain.
    logic [W-1:0]  path_mem [DEPTH];

    // State register and counters, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic: drain the stack, then walk the buffer back to slot 0
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    cnt_d   = '0;
                    len_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = CHK;
                end
            end
            CHK: begin
                if (stkEmpty) begin
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = IW'(cnt_q - 1'b1);
                        state_d = EMIT;
                    end
                end else if (cnt_q == CW'(DEPTH)) begin
                    // Buffer is full but the stack still has entries:
                    // stop without popping and flag the overflow.
                    ovf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = CAP;
            end
            CAP: begin
                wr_en   = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                len_d   = cnt_q + 1'b1;
                state_d = CHK;
            end
            EMIT: begin
                if (outReady) begin
                    if (idx_q == '0) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the stack word that appears the cycle after the pop
    always_ff @(posedge clk) begin
        if (wr_en) begin
            path_mem[cnt_q[IW-1:0]] <= stkLoc;
        end
    end

    // Moore outputs decoded from the current state
    always_comb begin
        stkPop   = (state_q == POP);
        outValid = (state_q == EMIT);
        outLoc   = (state_q == EMIT) ? path_mem[idx_q] : '0;
        busy     = (state_q != IDLE) && (state_q != DONE);
        done     = (state_q == DONE);
        pathLen  = len_q;
        ovf      = ovf_q;
    end

endmodule

// File: tb/tb_path_reader.sv
// Bench for path_reader: a behavioural stack feeds the DUT, and expected
// replay words are queued as each scenario loads the stack.
module tb_path_reader;

    localparam int W     = 8;
    localparam int DEPTH = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         stkEmpty;
    logic [W-1:0] stkLoc = '0;
    logic         stkPop;
    logic [W-1:0] outLoc;
    logic         outValid;
    logic         outReady;
    logic [6:0]   pathLen;
    logic         busy;
    logic         done;
    logic         ovf;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q [$];

    // Stack model
    logic [W-1:0] stk_mem [128];
    int           stk_sp   = 0;
    int           load_sp  = 0;
    logic         load_req = 1'b0;

    always #5 clk = ~clk;

    path_reader #(.W(W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stkEmpty (stkEmpty),
        .stkLoc   (stkLoc),
        .stkPop   (stkPop),
        .outLoc   (outLoc),
        .outValid (outValid),
        .outReady (outReady),
        .pathLen  (pathLen),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf)
    );

    // Stack pops on a sampled stkPop; the word appears on stkLoc next cycle
    always @(posedge clk) begin
        if (load_req) begin
            stk_sp <= load_sp;
        end else if (stkPop && stk_sp > 0) begin
            stkLoc <= stk_mem[stk_sp-1];
            stk_sp <= stk_sp - 1;
        end
    end

    assign stkEmpty = (stk_sp == 0);

    // mode 0: push 0x11,0x12,0x22 ; mode 1: push 1..n
    task automatic load_stack(input int n, input int mode);
        for (int i = 0; i < n; i++) stk_mem[i] = W'(i + 1);
        if (mode == 0) begin
            stk_mem[0] = 8'h11;
            stk_mem[1] = 8'h12;
            stk_mem[2] = 8'h22;
        end
        load_sp  = n;
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; outReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (stkPop !== 1'b0) begin errors++; $display("FAIL reset_stkPop: got %b expected 0", stkPop); end
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid: got %b expected 0", outValid); end
        checks++; if (outLoc !== '0) begin errors++; $display("FAIL reset_outLoc: got %h expected 00", outLoc); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
        checks++; if (ovf !== 1'b0 || pathLen !== 7'd0) begin errors++; $display("FAIL reset_ovf_len: got %b/%0d expected 0/0", ovf, pathLen); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int cyc = 0, pops = 0, last_pop = -1, last_out = -1;
        bit fin = 0;
        logic [W-1:0] e;
        load_stack(3, 0);
        exp_q.push_back(8'h11); exp_q.push_back(8'h12); exp_q.push_back(8'h22);
        outReady = 1'b1;
        pulse_start();
        while (!fin && cyc < 100) begin
            if (stkPop) begin
                pops++;
                if (last_pop >= 0) begin
                    checks++; if (cyc - last_pop != 3) begin errors++; $display("FAIL basic_pop_spacing: got %0d expected 3", cyc - last_pop); end
                end
                last_pop = cyc;
            end
            if (outValid) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL basic_extra_out: got %h expected none", outLoc); end
                else begin
                    e = exp_q.pop_front();
                    if (outLoc !== e) begin errors++; $display("FAIL basic_outLoc: got %h expected %h", outLoc, e); end
                end
                if (last_out >= 0) begin
                    checks++; if (cyc - last_out != 1) begin errors++; $display("FAIL basic_out_spacing: got %0d expected 1", cyc - last_out); end
                end
                last_out = cyc;
            end else if (outLoc !== '0) begin
                checks++; errors++; $display("FAIL basic_outLoc_idle: got %h expected 00", outLoc);
            end
            if (done) fin = 1;
            else begin @(posedge clk); #1; cyc++; end
        end
        checks++; if (!fin) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
        checks++; if (pops != 3) begin errors++; $display("FAIL basic_pops: got %0d expected 3", pops); end
        checks++; if (pathLen !== 7'd3) begin errors++; $display("FAIL basic_pathLen: got %0d expected 3", pathLen); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing_out: got %0d left expected 0", exp_q.size()); end
        checks++; if (ovf !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_flags: got ovf=%b busy=%b expected 0 0", ovf, busy); end
        exp_q.delete();
    endtask

    task automatic test_stall();
        int cyc = 0, stall = -1;
        bit fin = 0;
        logic [W-1:0] e;
        load_stack(3, 0);
        exp_q.push_back(8'h11); exp_q.push_back(8'h12); exp_q.push_back(8'h22);
        outReady = 1'b1;
        pulse_start();
        while (!fin && cyc < 100) begin
            if (outValid && stall == -1) stall = 4;
            if (stall > 0) begin
                outReady = 1'b0;
                checks++; if (outValid !== 1'b1 || outLoc !== 8'h11) begin errors++; $display("FAIL stall_hold: got v=%b loc=%h expected v=1 loc=11", outValid, outLoc); end
                stall--;
            end else begin
                outReady = 1'b1;
                if (outValid) begin
                    checks++;
                    if (exp_q.size() == 0) begin errors++; $display("FAIL stall_extra_out: got %h expected none", outLoc); end
                    else begin
                        e = exp_q.pop_front();
                        if (outLoc !== e) begin errors++; $display("FAIL stall_outLoc: got %h expected %h", outLoc, e); end
                    end
                end
            end
            if (done) fin = 1;
            else begin @(posedge clk); #1; cyc++; end
        end
        outReady = 1'b1;
        checks++; if (!fin) begin errors++; $display("FAIL stall_timeout: got no done expected done"); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_missing_out: got %0d left expected 0", exp_q.size()); end
        checks++; if (pathLen !== 7'd3) begin errors++; $display("FAIL stall_pathLen: got %0d expected 3", pathLen); end
        exp_q.delete();
    endtask

    task automatic test_overflow();
        int cyc = 0, pops = 0;
        bit fin = 0, vseen = 0;
        load_stack(65, 1);
        outReady = 1'b1;
        pulse_start();
        while (!fin && cyc < 400) begin
            if (stkPop) pops++;
            if (outValid) vseen = 1;
            if (done) fin = 1;
            else begin @(posedge clk); #1; cyc++; end
        end
        checks++; if (!fin) begin errors++; $display("FAIL ovf_timeout: got no done expected done"); end
        checks++; if (pops != 64) begin errors++; $display("FAIL ovf_pops: got %0d expected 64", pops); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", ovf); end
        checks++; if (vseen) begin errors++; $display("FAIL ovf_outValid: got 1 expected 0"); end
        checks++; if (pathLen !== 7'd64) begin errors++; $display("FAIL ovf_pathLen: got %0d expected 64", pathLen); end
        checks++; if (stk_sp != 1) begin errors++; $display("FAIL ovf_stack_left: got %0d expected 1", stk_sp); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ovf !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got ovf=%b done=%b expected 1 1", ovf, done); end
    endtask

    task automatic test_empty();
        load_stack(0, 1);
        pulse_start();
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL empty_chk: got busy=%b done=%b expected 1 0", busy, done); end
        checks++; if (pathLen !== 7'd0 || ovf !== 1'b0) begin errors++; $display("FAIL empty_cleared: got len=%0d ovf=%b expected 0 0", pathLen, ovf); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL empty_done: got %b expected 1", done); end
        checks++; if (stkPop !== 1'b0 || outValid !== 1'b0) begin errors++; $display("FAIL empty_quiet: got pop=%b v=%b expected 0 0", stkPop, outValid); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (outValid !== 1'b0 || pathLen !== 7'd0) begin errors++; $display("FAIL empty_hold: got v=%b len=%0d expected 0 0", outValid, pathLen); end
    endtask

    task automatic test_reset_mid();
        int cyc = 0, pops = 0, outs = 0;
        bit fin = 0;
        logic [W-1:0] e;
        load_stack(3, 0);
        outReady = 1'b1;
        pulse_start();
        while (pops < 2 && cyc < 50) begin
            if (stkPop) pops++;
            if (pops < 2) begin @(posedge clk); #1; cyc++; end
        end
        checks++; if (pops != 2) begin errors++; $display("FAIL rstmid_pops: got %0d expected 2", pops); end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if (stkPop !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_state: got pop=%b busy=%b expected 0 0", stkPop, busy); end
        checks++; if (pathLen !== 7'd0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_len: got len=%0d done=%b expected 0 0", pathLen, done); end
        checks++; if (stk_sp != 1) begin errors++; $display("FAIL rstmid_stack: got %0d expected 1", stk_sp); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(8'h11);
        pulse_start();
        cyc = 0;
        while (!fin && cyc < 50) begin
            if (outValid) begin
                outs++;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL rstmid_extra_out: got %h expected none", outLoc); end
                else begin
                    e = exp_q.pop_front();
                    if (outLoc !== e) begin errors++; $display("FAIL rstmid_outLoc: got %h expected %h", outLoc, e); end
                end
            end
            if (done) fin = 1;
            else begin @(posedge clk); #1; cyc++; end
        end
        checks++; if (!fin || outs != 1) begin errors++; $display("FAIL rstmid_outs: got %0d done=%b expected 1 1", outs, fin); end
        checks++; if (pathLen !== 7'd1) begin errors++; $display("FAIL rstmid_pathLen: got %0d expected 1", pathLen); end
        exp_q.delete();
    endtask

    task automatic test_start_in_emit();
        int cyc = 0;
        bit fin = 0;
        logic [W-1:0] e;
        load_stack(3, 0);
        exp_q.push_back(8'h11); exp_q.push_back(8'h12); exp_q.push_back(8'h22);
        outReady = 1'b1;
        pulse_start();
        while (!outValid && cyc < 50) begin @(posedge clk); #1; cyc++; end
        outReady = 1'b0;
        pulse_start();
        checks++; if (outValid !== 1'b1 || outLoc !== 8'h11) begin errors++; $display("FAIL emit_start_loc: got v=%b loc=%h expected v=1 loc=11", outValid, outLoc); end
        checks++; if (pathLen !== 7'd3 || busy !== 1'b1) begin errors++; $display("FAIL emit_start_len: got len=%0d busy=%b expected 3 1", pathLen, busy); end
        @(posedge clk); #1;
        checks++; if (outValid !== 1'b1 || outLoc !== 8'h11) begin errors++; $display("FAIL emit_start_hold: got v=%b loc=%h expected v=1 loc=11", outValid, outLoc); end
        outReady = 1'b1;
        cyc = 0;
        while (!fin && cyc < 50) begin
            if (outValid) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL emit_extra_out: got %h expected none", outLoc); end
                else begin
                    e = exp_q.pop_front();
                    if (outLoc !== e) begin errors++; $display("FAIL emit_outLoc: got %h expected %h", outLoc, e); end
                end
            end
            if (done) fin = 1;
            else begin @(posedge clk); #1; cyc++; end
        end
        checks++; if (!fin || exp_q.size() != 0) begin errors++; $display("FAIL emit_complete: got done=%b left=%0d expected 1 0", fin, exp_q.size()); end
        checks++; if (pathLen !== 7'd3) begin errors++; $display("FAIL emit_pathLen: got %0d expected 3", pathLen); end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_empty();
        test_reset_mid();
        test_start_in_emit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
